// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle, then a sign-fix/commit cycle.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] RSdata_i,
  input  logic [WIDTH-1:0] RTdata_i,
  input  logic             HIwrite_i,
  input  logic             LOwrite_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] HI_o,
  output logic [WIDTH-1:0] LO_o
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b10;

  state_t             state, state_nxt;
  logic [1:0]         op_q;
  logic               sign_a, sign_b, div0_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               is_signed_in, sa_in, sb_in, div0_in;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, rem_sh, rem_sub;
  logic               rem_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    is_signed_in = ~op_i[0];
    sa_in        = is_signed_in & RSdata_i[WIDTH-1];
    sb_in        = is_signed_in & RTdata_i[WIDTH-1];
    mag_a        = sa_in ? -RSdata_i : RSdata_i;
    mag_b        = sb_in ? -RTdata_i : RTdata_i;
    div0_in      = op_i[1] && (RTdata_i == '0);
  end

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide: acc[WIDTH-1:0] shifts dividend bits out and quotient bits in.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
    rem_sh   = {rem[WIDTH-1:0], acc[WIDTH-1]};
    rem_ge   = rem_sh >= {1'b0, b_q};
    rem_sub  = rem_sh - {1'b0, b_q};
    prod_fix = ((op_q == OP_MULT) && (sign_a ^ sign_b)) ? -acc : acc;
    quot_fix = ((op_q == OP_DIV) && (sign_a ^ sign_b)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = ((op_q == OP_DIV) && sign_a) ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = div0_in ? FIX : RUN;
      RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      div0_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      rem    <= '0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            op_q   <= op_i;
            sign_a <= sa_in;
            sign_b <= sb_in;
            div0_q <= div0_in;
            // Divide-by-zero returns the raw dividend in HI, so keep it unconverted.
            a_q    <= div0_in ? RSdata_i : mag_a;
            b_q    <= mag_b;
            acc    <= op_i[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
            rem    <= '0;
            cnt    <= '0;
          end else begin
            if (HIwrite_i) hi_q <= RSdata_i;
            if (LOwrite_i) lo_q <= RSdata_i;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (op_q[1]) begin
            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], rem_ge};
            rem            <= rem_ge ? rem_sub : rem_sh;
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        FIX: begin
          done_q <= 1'b1;
          if (div0_q) begin
            hi_q <= a_q;
            lo_q <= '1;
          end else if (op_q[1]) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (state != IDLE);
  assign done_o = done_q;
  assign HI_o   = hi_q;
  assign LO_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: latency, results, div-by-zero,
// ignored requests while busy, reset abort and MTHI/MTLO.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_i, start_i, HIwrite_i, LOwrite_i;
  logic [1:0]  op_i;
  logic [31:0] RSdata_i, RTdata_i;
  logic        busy_o, done_o;
  logic [31:0] HI_o, LO_o;

  int checks = 0;
  int errors = 0;
  int ncyc;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .RSdata_i(RSdata_i), .RTdata_i(RTdata_i),
    .HIwrite_i(HIwrite_i), .LOwrite_i(LOwrite_i),
    .busy_o(busy_o), .done_o(done_o), .HI_o(HI_o), .LO_o(LO_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the issue edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic hw);
    start_i   = 1'b1;
    op_i      = o;
    RSdata_i  = a;
    RTdata_i  = b;
    HIwrite_i = hw;
    @(negedge clk);
    start_i   = 1'b0;
    HIwrite_i = 1'b0;
  endtask

  // Counts busy cycles; returns at the negedge where done_o should be high.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (busy_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_timeout"}, busy_o, 0);
    check({tag, "_done"}, done_o, 1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(o, a, b, 1'b0);
    wait_done(tag, n);
    check({tag, "_busy_cycles"}, n, exp_cyc);
    check({tag, "_hi"}, HI_o, exp_hi);
    check({tag, "_lo"}, LO_o, exp_lo);
    @(negedge clk);
    check({tag, "_done_1cyc"}, done_o, 0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b1; op_i = MULTU;
    RSdata_i = 32'd5; RTdata_i = 32'd6; HIwrite_i = 1'b0; LOwrite_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi", HI_o, 0);
    check("rst_lo", LO_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    rst_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy_o, 0);

    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  MULT,  32'hFFFF_FFFD, 32'd7,         33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_min",  MULT,  32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0000_0000);
    run_op("div_negA",  DIV,   32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negB",  DIV,   32'd7,         32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div_wrap",  DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000);

    // Start together with MTHI: the write is dropped, HI keeps 0 until commit.
    issue(DIVU, 32'd100, 32'd7, 1'b1);
    check("start_beats_mthi", HI_o, 0);
    wait_done("divu", ncyc);
    check("divu_busy_cycles", ncyc, 33);
    check("divu_hi", HI_o, 2);
    check("divu_lo", LO_o, 14);

    // Back-to-back issue in the done cycle, divide by zero.
    issue(DIVU, 32'h0000_1234, 32'd0, 1'b0);
    check("div0_busy", busy_o, 1);
    wait_done("div0", ncyc);
    check("div0_busy_cycles", ncyc, 1);
    check("div0_hi", HI_o, 32'h0000_1234);
    check("div0_lo", LO_o, 32'hFFFF_FFFF);
    @(negedge clk);
    check("div0_done_1cyc", done_o, 0);

    run_op("divs0", DIV, 32'hFFFF_FFF0, 32'd0, 1, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

    // Start and MTHI while busy are ignored.
    issue(MULT, 32'd5, 32'hFFFF_FFFA, 1'b0);
    repeat (5) @(negedge clk);
    start_i = 1'b1; HIwrite_i = 1'b1; op_i = DIVU; RSdata_i = 32'hDEAD; RTdata_i = 32'd0;
    @(negedge clk);
    start_i = 1'b0; HIwrite_i = 1'b0;
    check("busy_mthi_ignored", HI_o, 32'hFFFF_FFF0);
    wait_done("interf", ncyc);
    check("interf_busy_cycles", ncyc, 27);
    check("interf_hi", HI_o, 32'hFFFF_FFFF);
    check("interf_lo", LO_o, 32'hFFFF_FFE2);
    @(negedge clk);

    // Reset mid-operation aborts without committing.
    issue(MULT, 32'd7, 32'd9, 1'b0);
    repeat (9) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_hi", HI_o, 0);
    check("abort_lo", LO_o, 0);
    @(negedge clk);
    check("abort_no_done", done_o, 0);
    check("abort_idle", busy_o, 0);

    LOwrite_i = 1'b1; RSdata_i = 32'h55;
    @(negedge clk);
    LOwrite_i = 1'b0; RSdata_i = 32'h77;
    check("mtlo_lo", LO_o, 32'h55);
    check("mtlo_hi", HI_o, 0);
    HIwrite_i = 1'b1;
    @(negedge clk);
    HIwrite_i = 1'b0;
    check("mthi_hi", HI_o, 32'h77);
    repeat (3) @(negedge clk);
    check("hold_hi", HI_o, 32'h77);
    check("hold_lo", LO_o, 32'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the pipelined MIPS core.
- Consumes the two source operands read from the register file (RS/RT) and produces HI/LO, which MFHI/MFLO return to the register file through writeback.
- Runs multi-cycle and raises busy_o so hazard control stalls IF/ID/EX until the result is committed.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous reset, active-high.
- start_i  input  1  issue request, sampled only in IDLE.
- op_i  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- RSdata_i  input  32  operand A (multiplicand or dividend).
- RTdata_i  input  32  operand B (multiplier or divisor).
- HIwrite_i  input  1  MTHI write enable.
- LOwrite_i  input  1  MTLO write enable.
- busy_o  output  1  operation in flight; drives the stall.
- done_o  output  1  one-cycle pulse when HI/LO are committed.
- HI_o  output  32  HI register.
- LO_o  output  32  LO register.

Behaviour:
- Clocking and reset: one clock domain (clk_i). rst_i is synchronous and active-high, checked at each rising edge with priority over everything else.
- Reset values: state=IDLE, HI_o=0, LO_o=0, done_o=0, busy_o=0, counter=0, internal datapath registers=0. Asserting reset mid-operation aborts the operation; HI/LO are not updated with the partial result.
- States:
  - IDLE: accepting requests.
  - RUN: one iteration per cycle.
  - FIX: sign correction and HI/LO commit.
- busy_o = (state != IDLE), decoded from state.
- Issue (edge E0): in IDLE with start_i=1, latch op_i.
  - Signed ops (00, 10): latch operand magnitudes plus the sign bits.
  - Unsigned ops (01, 11): latch operands as-is.
  - Clear counter and go to RUN.
  - Exception: DIV/DIVU with RTdata_i==0 goes directly to FIX.
- RUN, multiply: shift-add, one multiplier bit per cycle into a 64-bit product accumulator.
- RUN, divide: restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
- RUN to FIX: after exactly WIDTH iterations, at edge E32.
- FIX commit (edge E33): write HI/LO, done_o=1 for the following cycle only, go to IDLE.
  - Multiply: {HI,LO} = 64-bit product. For MULT, negate the product if signA^signB.
  - Divide: LO = quotient, HI = remainder. For DIV, negate the quotient if signA^signB and negate the remainder if signA.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (natural wrap, no trap).
  - Divide by zero, any signedness: HI = RSdata latched at issue, LO = 0xFFFFFFFF. Commit happens at E1, so done_o is high the cycle after E1.
- Latency: busy_o is high the cycle after E0 through the cycle containing E33, i.e. 33 cycles (1 cycle for divide-by-zero). The result is visible on HI_o/LO_o in the same cycle that done_o=1.
- start_i while busy: ignored; the operation in flight is unaffected.
- HIwrite_i/LOwrite_i:
  - Honoured only in IDLE with start_i=0: HI <= RSdata_i and/or LO <= RSdata_i at the edge.
  - While busy: ignored.
  - Simultaneous with start_i in IDLE: start wins and the writes are dropped.
- Back-to-back: start_i may be asserted in the cycle done_o=1. State is IDLE then, so the request is accepted.
- Outside an operation, HI_o/LO_o hold their values indefinitely.

Test Plan:
- Reset: rst_i high for 2 cycles with start_i=1 → HI_o=LO_o=0, busy_o=0, done_o=0; no operation starts.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → busy_o high for 33 cycles, then done_o pulse; HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV signs:
  - -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 100 / 7 → LO=14, HI=2.
  - DIV 0x80000000 / -1 → LO=0x80000000, HI=0.
- Divide by zero: DIVU 0x1234 / 0 → busy_o high 1 cycle; HI=0x1234, LO=0xFFFFFFFF; done_o pulses.
- Interference: mid-MULT, pulse start_i and HIwrite_i (RSdata_i=0xDEAD) → ignored, result correct. Then assert rst_i at iteration 10 of a second MULT → state IDLE, HI=LO=0 next cycle. Then MTLO 0x55 in IDLE → LO=0x55.
